// File: rtl/pbkdf2_iter.sv
// PBKDF2 iteration controller: drives one HMAC-SHA256 instance through c rounds,
// feeding each PRF result back as the next message and XOR-accumulating it into T.
module pbkdf2_iter #(
   parameter int ITER_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [255:0]      pw_i,
   input  logic [255:0]      salt_i,
   input  logic [ITER_W-1:0] iters_i,
   input  logic              v_i,
   output logic              r_o,
   output logic [255:0]      dk_o,
   output logic              v_o,
   input  logic              r_i,
   output logic [255:0]      hmac_key_o,
   output logic [255:0]      hmac_msg_o,
   output logic              hmac_v_o,
   input  logic              hmac_r_i,
   input  logic [255:0]      hmac_prf_i,
   input  logic              hmac_v_i,
   output logic              hmac_r_o
);

   // Handshakes: a transfer happens on a rising clk_i edge where the sender's
   // valid and the receiver's ready are both high; valid/data hold until then.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state;
   logic [255:0]      key_q;
   logic [255:0]      msg_q;
   logic [255:0]      t_q;
   logic [ITER_W-1:0] c_q;
   logic [ITER_W-1:0] cnt_q;
   logic [ITER_W-1:0] cnt_nxt;

   // cnt_q never exceeds c_q-1 before the increment, so this cannot wrap.
   assign cnt_nxt = cnt_q + ITER_W'(1);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
         key_q <= '0;
         msg_q <= '0;
         t_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (v_i) begin
                  key_q <= pw_i;
                  msg_q <= {salt_i[255:32], 32'h0000_0001};
                  c_q   <= (iters_i == '0) ? ITER_W'(1) : iters_i;
                  cnt_q <= '0;
                  t_q   <= '0;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (hmac_r_i) state <= S_WAIT;
            end
            S_WAIT: begin
               if (hmac_v_i) begin
                  t_q   <= t_q ^ hmac_prf_i;
                  msg_q <= hmac_prf_i;
                  cnt_q <= cnt_nxt;
                  state <= (cnt_nxt == c_q) ? S_DONE : S_SEND;
               end
            end
            S_DONE: begin
               if (r_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign r_o        = (state == S_IDLE);
   assign hmac_v_o   = (state == S_SEND);
   assign hmac_r_o   = (state == S_WAIT);
   assign v_o        = (state == S_DONE);
   assign dk_o       = t_q;
   assign hmac_key_o = key_q;
   assign hmac_msg_o = msg_q;

endmodule

// File: tb/tb_pbkdf2_iter.sv
// Bench for pbkdf2_iter with a stub HMAC responder computing PRF = key ^ msg
// after a 3+ cycle latency; requests and derived keys are checked via queues.
module tb_pbkdf2_iter;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [255:0] pw_i;
   logic [255:0] salt_i;
   logic [31:0]  iters_i;
   logic         v_i;
   logic         r_o;
   logic [255:0] dk_o;
   logic         v_o;
   logic         r_i;
   logic [255:0] hmac_key_o;
   logic [255:0] hmac_msg_o;
   logic         hmac_v_o;
   logic         hmac_r_i;
   logic [255:0] hmac_prf_i;
   logic         hmac_v_i;
   logic         hmac_r_o;

   pbkdf2_iter #(.ITER_W(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pw_i       (pw_i),
      .salt_i     (salt_i),
      .iters_i    (iters_i),
      .v_i        (v_i),
      .r_o        (r_o),
      .dk_o       (dk_o),
      .v_o        (v_o),
      .r_i        (r_i),
      .hmac_key_o (hmac_key_o),
      .hmac_msg_o (hmac_msg_o),
      .hmac_v_o   (hmac_v_o),
      .hmac_r_i   (hmac_r_i),
      .hmac_prf_i (hmac_prf_i),
      .hmac_v_i   (hmac_v_i),
      .hmac_r_o   (hmac_r_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [255:0] exp_q[$];
   logic [255:0] req_q[$];
   logic [255:0] cur_key;
   int           cur_c;
   int           job_reqs;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- stub HMAC responder ----------------
   logic         rdy_rand;
   logic         hold_r;
   logic         spur_v;
   logic         stub_busy;
   logic         stub_v;
   int           stub_cnt;
   logic [255:0] stub_prf;

   assign hmac_r_i   = rdy_rand && !stub_busy && !hold_r;
   assign hmac_v_i   = stub_v || spur_v;
   assign hmac_prf_i = stub_v ? stub_prf : {8{32'hDEAD_BEEF}};

   always @(negedge clk_i) rdy_rand = 1'($urandom_range(0, 1));

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stub_busy <= 1'b0;
         stub_v    <= 1'b0;
         stub_cnt  <= 0;
         stub_prf  <= '0;
      end else if (!stub_busy && hmac_v_o && hmac_r_i) begin
         stub_busy <= 1'b1;
         stub_cnt  <= 3 + int'($urandom_range(0, 3));
         stub_prf  <= hmac_key_o ^ hmac_msg_o;
      end else if (stub_busy && !stub_v) begin
         if (stub_cnt <= 1) stub_v <= 1'b1;
         else stub_cnt <= stub_cnt - 1;
      end else if (stub_v && hmac_r_o) begin
         stub_v    <= 1'b0;
         stub_busy <= 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_i) begin
      #2;
      if (rst_i) begin
         if (hmac_v_o && hmac_r_i) begin
            job_reqs++;
            if (req_q.size() == 0) chk("req_unexpected", 256'(req_q.size()), 256'd1);
            else begin
               chk("req_msg", hmac_msg_o, req_q.pop_front());
               chk("req_key", hmac_key_o, cur_key);
            end
         end
         if (v_o && r_i) begin
            if (exp_q.size() == 0) chk("dk_unexpected", 256'(exp_q.size()), 256'd1);
            else chk("dk_sb", dk_o, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_job(input logic [255:0] pw, input logic [255:0] salt, input logic [31:0] iters);
      logic [255:0] m;
      logic [255:0] t;
      logic [255:0] u;
      int           c;
      @(negedge clk_i);
      pw_i    = pw;
      salt_i  = salt;
      iters_i = iters;
      v_i     = 1'b1;
      for (int i = 0; i < 200 && !r_o; i++) @(negedge clk_i);
      if (!r_o) chk("accept_timeout", 256'(r_o), 256'd1);
      c = (iters == 0) ? 1 : int'(iters);
      m = {salt[255:32], 32'h0000_0001};
      t = '0;
      for (int k = 0; k < c; k++) begin
         req_q.push_back(m);
         u = pw ^ m;
         t = t ^ u;
         m = u;
      end
      exp_q.push_back(t);
      cur_key  = pw;
      cur_c    = c;
      job_reqs = 0;
      @(negedge clk_i);
      v_i = 1'b0;
   endtask

   task automatic finish_job(input int hold, input logic [255:0] exp_dk, input string tag);
      int held = 0;
      bit done = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(negedge clk_i);
         if (v_o) begin
            if (held < hold) begin
               r_i = 1'b0;
               chk({tag, "_dk_hold"}, dk_o, exp_dk);
               chk({tag, "_r_o_hold"}, 256'(r_o), 256'd0);
               held++;
            end else begin
               r_i  = 1'b1;
               done = 1;
            end
         end else begin
            r_i = 1'($urandom_range(0, 1));
         end
      end
      if (!done) chk({tag, "_finish_timeout"}, 256'(done), 256'd1);
      @(negedge clk_i);
      r_i = 1'b0;
      chk({tag, "_r_o_after"}, 256'(r_o), 256'd1);
      chk({tag, "_v_o_after"}, 256'(v_o), 256'd0);
      chk({tag, "_dk"}, dk_o, exp_dk);
      chk({tag, "_req_count"}, 256'(job_reqs), 256'(cur_c));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_r_o"}, 256'(r_o), 256'd1);
      chk({tag, "_v_o"}, 256'(v_o), 256'd0);
      chk({tag, "_hmac_v_o"}, 256'(hmac_v_o), 256'd0);
      chk({tag, "_hmac_r_o"}, 256'(hmac_r_o), 256'd0);
      chk({tag, "_dk_o"}, dk_o, 256'd0);
      chk({tag, "_hmac_key_o"}, hmac_key_o, 256'd0);
      chk({tag, "_hmac_msg_o"}, hmac_msg_o, 256'd0);
   endtask

   // ---------------- main sequence ----------------
   logic [255:0] pw_a;
   logic [255:0] salt_a;
   logic [255:0] m1;

   initial begin
      rst_i   = 1'b0;
      pw_i    = '0;
      salt_i  = '0;
      iters_i = '0;
      v_i     = 1'b0;
      r_i     = 1'b0;
      hold_r  = 1'b0;
      spur_v  = 1'b0;
      job_reqs = 0;
      cur_c    = 0;
      cur_key  = '0;
      pw_a   = {32{8'hA5}};
      salt_a = {32{8'h0F}};
      m1     = {salt_a[255:32], 32'h0000_0001};

      repeat (3) @(negedge clk_i);
      check_reset_outputs("reset");
      rst_i = 1'b1;

      start_job(pw_a, salt_a, 32'd1);
      finish_job(0, m1 ^ pw_a, "iters1");
      start_job(pw_a, salt_a, 32'd2);
      finish_job(0, pw_a, "iters2");
      start_job(pw_a, salt_a, 32'd3);
      finish_job(0, m1, "iters3");
      start_job(pw_a, salt_a, 32'd0);
      finish_job(0, m1 ^ pw_a, "iters0");

      // back-pressure in SEND and DONE
      hold_r = 1'b1;
      start_job(pw_a, salt_a, 32'd2);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hmac_v_o", 256'(hmac_v_o), 256'd1);
         chk("bp_hmac_msg_o", hmac_msg_o, m1);
         chk("bp_hmac_key_o", hmac_key_o, pw_a);
         chk("bp_r_o", 256'(r_o), 256'd0);
         @(negedge clk_i);
      end
      hold_r = 1'b0;
      finish_job(20, pw_a, "bp");

      // asynchronous reset in the middle of WAIT
      start_job(pw_a, salt_a, 32'd5);
      begin
         bit hit = 0;
         for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk_i);
            #3;
            if (job_reqs >= 3 && hmac_r_o) hit = 1;
         end
         chk("midwait_reached", 256'(hit), 256'd1);
      end
      rst_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      req_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      start_job(pw_a, salt_a, 32'd1);
      finish_job(0, m1 ^ pw_a, "after_rst");

      // spurious hmac_v_i in SEND and v_i noise while busy
      begin
         logic [255:0] pw_b;
         logic [255:0] salt_b;
         logic [255:0] m1b;
         bit           spur_done = 0;
         pw_b   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         salt_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         m1b    = {salt_b[255:32], 32'h0000_0001};
         start_job(pw_b, salt_b, 32'd3);
         for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            spur_v = 1'b0;
            hold_r = 1'b0;
            v_i    = 1'($urandom_range(0, 1));
            pw_i   = {8{$urandom}};
            iters_i = 32'd7;
            if (hmac_v_o && !spur_done && i > 2) begin
               spur_v    = 1'b1;
               hold_r    = 1'b1;
               spur_done = 1;
            end
         end
         @(negedge clk_i);
         spur_v = 1'b0;
         hold_r = 1'b0;
         v_i    = 1'b0;
         finish_job(0, m1b, "spur");
      end

      // random jobs
      for (int j = 0; j < 4; j++) begin
         logic [255:0] pw_r;
         logic [255:0] salt_r;
         logic [255:0] m1r;
         logic [255:0] t;
         logic [255:0] m;
         int           c;
         pw_r   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         salt_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         c = int'($urandom_range(1, 6));
         m1r = {salt_r[255:32], 32'h0000_0001};
         m = m1r;
         t = '0;
         for (int k = 0; k < c; k++) begin
            m = pw_r ^ m;
            t = t ^ m;
         end
         start_job(pw_r, salt_r, 32'(c));
         finish_job(int'($urandom_range(0, 3)), t, "rand");
      end

      repeat (5) @(negedge clk_i);
      chk("exp_q_empty", 256'(exp_q.size()), 256'd0);
      chk("req_q_empty", 256'(req_q.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
